// File: rtl/seg7_pkg.sv
// Shared constants and hex-to-segment lookup for the 7-segment scan driver.
// Latency: n/a (constants and pure function only).
// Backpressure: n/a.
package seg7_pkg;

    // Bit positions of each segment in a 7-bit pattern (bit0 = a ... bit6 = g).
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Active-high lit-segment patterns for hex digits 0..F.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F,  // 0: abcdef
        7'h06,  // 1: bc
        7'h5B,  // 2: abdeg
        7'h4F,  // 3: abcdg
        7'h66,  // 4: bcfg
        7'h6D,  // 5: acdfg
        7'h7D,  // 6: acdefg
        7'h07,  // 7: abc
        7'h7F,  // 8: all
        7'h6F,  // 9: abcdfg
        7'h77,  // A: abcefg
        7'h7C,  // b: cdefg
        7'h39,  // C: adef
        7'h5E,  // d: bcdeg
        7'h79,  // E: adefg
        7'h71   // F: aefg
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        return SEG_TABLE[hex];
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-high 7-segment pattern.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Table lookup; output polarity is handled by the caller.
    always_comb begin
        seg = hex_to_seg(hex);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-seg driver: shadow/display latching, LZ blanking, ghost gap.
// Latency: outputs registered; load visible at next frame wrap (1 cycle if load hits the wrap tick).
// Backpressure: none; load is a strobe, the last load before a wrap wins.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 100000,
    parameter int GHOST_CYC      = 2,
    parameter int ACTIVE_LOW_SEG = 1,
    parameter int ACTIVE_LOW_AN  = 1,
    parameter int LZ_BLANK       = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PS_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    // Inactive levels double as XOR masks that convert active-high to pin polarity.
    localparam logic [6:0]            SEG_OFF = (ACTIVE_LOW_SEG != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF  = (ACTIVE_LOW_SEG != 0);
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = (ACTIVE_LOW_AN != 0) ? '1 : '0;

    logic [PS_W-1:0]           presc, presc_nxt;
    logic [IDX_W-1:0]          idx, idx_nxt;
    logic                      tick, wrap;
    logic                      pending;
    logic [4*NUM_DIGITS-1:0]   sh_val, disp_val, disp_val_nxt;
    logic [NUM_DIGITS-1:0]     sh_dp, disp_dp, disp_dp_nxt;
    logic [NUM_DIGITS-1:0]     sh_blank, disp_blank, disp_blank_nxt;

    logic [3:0]                nibble;
    logic                      dig_dp, dig_blank, upper_zero, lz_dark;
    logic [6:0]                seg_pat, seg_hi;
    logic                      dp_hi;
    logic [NUM_DIGITS-1:0]     an_hi;

    // Scan timing and frame-synchronous display transfer; a load on the wrap tick bypasses the shadow.
    always_comb begin
        tick           = (presc == PS_W'(CLK_DIV - 1));
        wrap           = tick && (idx == IDX_W'(NUM_DIGITS - 1));
        presc_nxt      = tick ? '0 : presc + 1'b1;
        idx_nxt        = idx;
        disp_val_nxt   = disp_val;
        disp_dp_nxt    = disp_dp;
        disp_blank_nxt = disp_blank;
        if (tick) begin
            idx_nxt = wrap ? '0 : idx + 1'b1;
        end
        if (wrap && load) begin
            disp_val_nxt   = value;
            disp_dp_nxt    = dp_in;
            disp_blank_nxt = blank_in;
        end else if (wrap && pending) begin
            disp_val_nxt   = sh_val;
            disp_dp_nxt    = sh_dp;
            disp_blank_nxt = sh_blank;
        end
    end

    // Select the digit entering the next cycle and decide blanking and anode gating for it.
    always_comb begin
        nibble     = '0;
        dig_dp     = 1'b0;
        dig_blank  = 1'b0;
        upper_zero = 1'b1;
        an_hi      = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IDX_W'(i) == idx_nxt) begin
                nibble    = disp_val_nxt[4*i +: 4];
                dig_dp    = disp_dp_nxt[i];
                dig_blank = disp_blank_nxt[i];
                an_hi[i]  = 1'b1;
            end
            if (i >= int'(idx_nxt) && disp_val_nxt[4*i +: 4] != 4'h0) begin
                upper_zero = 1'b0;
            end
        end
        // Digit 0 always shows, so a zero value still reads "0".
        lz_dark = (LZ_BLANK != 0) && (idx_nxt != '0) && upper_zero;
        seg_hi  = (dig_blank || lz_dark) ? 7'h00 : seg_pat;
        // Decimal point follows only the explicit blank, not leading-zero suppression.
        dp_hi   = dig_dp && !dig_blank;
        if (int'(presc_nxt) < GHOST_CYC) begin
            an_hi = '0;
        end
    end

    seg7_hex_decode u_decode (
        .hex (nibble),
        .seg (seg_pat)
    );

    // Scan counters, shadow/display registers and pending flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc      <= '0;
            idx        <= '0;
            pending    <= 1'b0;
            sh_val     <= '0;
            sh_dp      <= '0;
            sh_blank   <= '0;
            disp_val   <= '0;
            disp_dp    <= '0;
            disp_blank <= '0;
        end else begin
            presc      <= presc_nxt;
            idx        <= idx_nxt;
            disp_val   <= disp_val_nxt;
            disp_dp    <= disp_dp_nxt;
            disp_blank <= disp_blank_nxt;
            pending    <= wrap ? 1'b0 : (pending | load);
            if (load) begin
                sh_val   <= value;
                sh_dp    <= dp_in;
                sh_blank <= blank_in;
            end
        end
    end

    // Registered pin outputs, converted to the configured polarity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg        <= SEG_OFF;
            dp         <= DP_OFF;
            an         <= AN_OFF;
            frame_done <= 1'b0;
        end else begin
            seg        <= seg_hi ^ SEG_OFF;
            dp         <= dp_hi ^ DP_OFF;
            an         <= an_hi ^ AN_OFF;
            frame_done <= wrap;
        end
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised, time-multiplexed driver for a common-anode multi-digit 7-segment display. Latches a packed hex value, decodes each nibble to segment patterns, and scans the digits at a programmable refresh rate. Includes a ghost-suppression gap, leading-zero blanking and tear-free frame-synchronous updates. Sits between the calculator result register and the board display pins; replaces the per-segment combinational decoders.

## Interface
Parameters:
- NUM_DIGITS, 4: digits scanned; legal 1..8.
- CLK_DIV, 100000: clock cycles per digit slot; legal ≥ GHOST_CYC+1.
- GHOST_CYC, 2: cycles at the start of each slot with all anodes off.
- ACTIVE_LOW_SEG, 1: 1 = segment/dp outputs driven low when lit.
- ACTIVE_LOW_AN, 1: 1 = anode outputs driven low when enabled.
- LZ_BLANK, 1: 1 = blank leading zeros.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- load  in  1  one-cycle strobe; capture value/dp_in/blank_in.
- value  in  4*NUM_DIGITS  hex digits; nibble i → digit i (digit 0 = rightmost).
- dp_in  in  NUM_DIGITS  decimal point per digit (1 = lit).
- blank_in  in  NUM_DIGITS  force digit blank (1 = dark, dp included).
- seg  out  7  segments, bit0 = a … bit6 = g, polarity per ACTIVE_LOW_SEG.
- dp  out  1  decimal point, polarity per ACTIVE_LOW_SEG.
- an  out  NUM_DIGITS  anode enables, one-hot when active, polarity per ACTIVE_LOW_AN.
- frame_done  out  1  one-cycle pulse when scan index wraps to 0.

## Operation
- Registers: prescaler (0..CLK_DIV-1), digit index idx (0..NUM_DIGITS-1), shadow set {value, dp, blank}, display set, pending flag.
- Prescaler increments each cycle. When it equals CLK_DIV-1 it issues tick and returns to 0. On tick, idx advances; NUM_DIGITS-1 wraps to 0, and the wrap cycle pulses frame_done.
- load: shadow ← inputs, pending ← 1. A second load before transfer overwrites the shadow; the last one wins.
- Transfer: on the wrap tick with pending=1, display ← shadow and pending ← 0.
- Transfer on a load coinciding with the wrap tick:
  - The load's data goes straight into display.
  - pending ends at 0.
- Decode: standard hex 0–F. Lit segments:
  - 0 = abcdef, 1 = bc, 2 = abdeg, 3 = abcdg, 4 = bcfg, 5 = acdfg, 6 = acdefg, 7 = abc
  - 8 = all, 9 = abcdfg, A = abcefg, b = cdefg, C = adef, d = bcdeg, E = adefg, F = aefg
- Digit dark when blank[idx]=1, or when all of the following hold:
  - LZ_BLANK=1;
  - idx>0;
  - every nibble at index ≥ idx is 0.
- Digit 0 is never LZ-blanked. dp is suppressed only by blank_in, not by LZ.
- Anodes: all inactive while prescaler < GHOST_CYC; otherwise only an[idx] is active.
- Reset: prescaler=0, idx=0, shadow/display=0, pending=0.
- Reset outputs:
  - an all inactive, seg all dark, dp dark (inactive level per polarity parameter);
  - frame_done=0.
- Reset asserted mid-scan aborts immediately; after release, scanning restarts at digit 0 with the ghost gap.

## Timing
- seg, dp, an and frame_done are registered, with no combinational input-to-output path.
- Outputs for slot idx appear the cycle after the tick that selects idx. seg/dp are valid from the first cycle of the slot; an is asserted from slot cycle GHOST_CYC.
- Load-to-display latency:
  - at most NUM_DIGITS·CLK_DIV + 1 cycles;
  - exactly 1 cycle when load coincides with the wrap tick.
- frame_done period is NUM_DIGITS·CLK_DIV cycles.
- First frame_done after reset release is at cycle NUM_DIGITS·CLK_DIV.

## Structure
- Package seg7_pkg holds:
  - segment index constants SEG_A..SEG_G;
  - 16-entry active-high pattern table;
  - hex_to_seg function.
- Sub-module seg7_hex_decode: combinational, 4-bit in → 7-bit active-high pattern, from the package table. Polarity inversion is applied only in the top.

## Test plan
Bench parameters: NUM_DIGITS=4, CLK_DIV=4, GHOST_CYC=1, active-low.
- Reset then idle: all outputs at their inactive level. an=4'b1111 for the first cycle, then cycles 0,1,2,3 one-hot low. frame_done first pulses at cycle 16.
- load value=16'h12AF, dp_in=4'b0100 mid-frame: display unchanged until the next wrap. Then digit 0 seg=~7'b1110001 (F), digit 1 A, digit 2 "2" with dp low, digit 3 "1".
- load 16'h0007, LZ_BLANK=1: digits 1–3 dark, digit 0 shows 7 (seg=~7'b0000111). Repeat with LZ_BLANK=0: digits 1–3 show 0.
- Two loads in one frame (16'h1111 then 16'h2222): only 2222 is ever shown. Load on the wrap tick: visible next cycle, pending=0.
- blank_in=4'b0010 with dp_in=4'b0010: digit 1 seg and dp dark, anode still scans.
- Assert rst_n low mid-slot 2: outputs go inactive asynchronously. After release, restart at digit 0 and display=0.
